// File: rtl/instruction_loader.sv
// instruction_loader: packs a byte-stream program image into 32-bit words and writes them to instruction memory
module instruction_loader #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ins_address,
  output logic [31:0]       ins_write_data,
  output logic              ins_write_enable,
  output logic              ins_read_enable,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_overflow,
  output logic [15:0]       words_written
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE} state_t;
  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  assign in_ready        = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign load_busy       = in_ready || (state == WRITE);
  assign cpu_hold        = load_busy;
  assign ins_read_enable = ~load_busy;
  assign load_done       = state == DONE;
  // header capture, byte packing and the one-cycle write strobe issued on entry to WRITE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      count            <= '0;
      word_idx         <= '0;
      byte_idx         <= '0;
      word_buf         <= '0;
      ins_address      <= BASE_ADDR;
      ins_write_data   <= '0;
      ins_write_enable <= 1'b0;
      load_overflow    <= 1'b0;
      words_written    <= '0;
    end else begin
      ins_write_enable <= 1'b0;
      case (state)
        IDLE, DONE: if (load_start) begin
          state         <= HDR0;
          load_overflow <= 1'b0;
          words_written <= '0;
        end
        HDR0: if (in_valid) begin
          count[7:0] <= in_data;
          state      <= HDR1;
        end
        HDR1: if (in_valid) begin
          count[15:8] <= in_data;
          word_idx    <= '0;
          byte_idx    <= '0;
          state       <= ({in_data, count[7:0]} == 16'd0) ? DONE : DATA;
        end
        DATA: if (in_valid) begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state          <= WRITE;
            ins_write_data <= {in_data, word_buf};
            if ({16'd0, word_idx} < DEPTH_WORDS) begin
              ins_write_enable <= 1'b1;
              ins_address      <= BASE_ADDR + ADDR_W'({word_idx, 2'b00});
              words_written    <= words_written + 16'd1;
            end else begin
              load_overflow <= 1'b1;
            end
          end else begin
            word_buf[8*byte_idx +: 8] <= in_data;
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          state    <= (word_idx + 16'd1 == count) ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: scoreboard bench for instruction_loader with a small memory to exercise overflow
module tb_instruction_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [31:0] ins_address;
  logic [31:0] ins_write_data;
  logic        ins_write_enable;
  logic        ins_read_enable;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_overflow;
  logic [15:0] words_written;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] img[$];
  int         total = 0;
  int         passed = 0;
  instruction_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH_WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ins_address(ins_address), .ins_write_data(ins_write_data),
    .ins_write_enable(ins_write_enable), .ins_read_enable(ins_read_enable), .cpu_hold(cpu_hold),
    .load_busy(load_busy), .load_done(load_done), .load_overflow(load_overflow), .words_written(words_written)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  // monitor: every write strobe must match the next expected write and must not coincide with in_ready
  always @(negedge clk) begin
    if (reset_n && ins_write_enable) begin
      if (exp_q.size() == 0) chk("extra_strobe", 32'd1, 32'd0);
      else begin
        chk("wr_addr", ins_address, exp_q[0].a);
        chk("wr_data", ins_write_data, exp_q[0].d);
        chk("ready_in_write", {31'd0, in_ready}, 32'd0);
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic send_img(input bit gap);
    foreach (img[i]) send(img[i], gap);
  endtask
  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!load_done && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_done"}, {31'd0, load_done}, 32'd1);
    chk({name, "_hold_off"}, {31'd0, cpu_hold}, 32'd0);
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_outputs", {in_ready, ins_write_enable, cpu_hold, load_busy, load_done, load_overflow}, 32'd0);
    chk("rst_read_en", {31'd0, ins_read_enable}, 32'd1);
    chk("rst_addr_ww", ins_address | {16'd0, words_written}, 32'd0);
    reset_n = 1'b1;
    tick();
    start();
    chk("hold_after_start", {cpu_hold, load_busy, ins_read_enable}, 32'b110);
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    push(32'h0, 32'h00100513);
    push(32'h4, 32'h00200593);
    send_img(1'b0);
    wait_done("basic");
    chk("basic_ww", {16'd0, words_written}, 32'd2);
    chk("basic_drained", exp_q.size(), 32'd0);
    start();
    chk("restart_clears_done", {31'd0, load_done}, 32'd0);
    chk("restart_ww_clear", {16'd0, words_written}, 32'd0);
    push(32'h0, 32'h00100513);
    push(32'h4, 32'h00200593);
    send_img(1'b1);
    wait_done("gap");
    chk("gap_ww", {16'd0, words_written}, 32'd2);
    chk("gap_drained", exp_q.size(), 32'd0);
    start();
    img = '{8'h00, 8'h00};
    send_img(1'b0);
    chk("zero_done_now", {31'd0, load_done}, 32'd1);
    chk("zero_ww", {16'd0, words_written}, 32'd0);
    start();
    push(32'h0, 32'h03020100);
    push(32'h4, 32'h07060504);
    push(32'h8, 32'h0B0A0908);
    push(32'hC, 32'h0F0E0D0C);
    send(8'h06, 1'b0);
    send(8'h00, 1'b0);
    for (int j = 0; j < 24; j++) begin
      if (j == 9) load_start = 1'b1;
      send(8'(j), 1'b0);
      load_start = 1'b0;
    end
    wait_done("ovf");
    chk("ovf_flag", {31'd0, load_overflow}, 32'd1);
    chk("ovf_ww", {16'd0, words_written}, 32'd4);
    chk("ovf_drained", exp_q.size(), 32'd0);
    start();
    chk("restart_ovf_clear", {load_overflow, load_done}, 32'd0);
    chk("restart_busy", {31'd0, load_busy}, 32'd1);
    push(32'h0, 32'hDDCCBBAA);
    img = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_img(1'b0);
    reset_n = 1'b0;
    tick();
    chk("abort_state", {cpu_hold, load_busy, in_ready, ins_read_enable}, 32'b0001);
    chk("abort_drained", exp_q.size(), 32'd0);
    reset_n = 1'b1;
    tick();
    start();
    push(32'h0, 32'h12345678);
    img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_img(1'b0);
    wait_done("after_abort");
    chk("after_abort_ww", {16'd0, words_written}, 32'd1);
    tick();
    chk("final_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the instruction memory. Accepts a program image as a byte stream (valid/ready) and packs bytes into little-endian 32-bit words. Writes each word into instruction_memory through ins_address / ins_write_data / ins_write_enable at consecutive word addresses. Holds the CPU (drives the pc reset request) for the whole load and releases it when the image is complete.

Parameters:
ADDR_W, 32, width of ins_address (byte address)
BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4
DEPTH_WORDS, 256, instruction memory capacity in words; words beyond this are consumed but not written

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
load_start  input  1  one-cycle pulse that starts a load; ignored unless state is IDLE or DONE
in_valid  input  1  byte stream valid
in_data  input  8  byte stream data
in_ready  output  1  byte accepted on a cycle where in_valid && in_ready
ins_address  output  ADDR_W  instruction memory byte address
ins_write_data  output  32  instruction memory write data
ins_write_enable  output  1  one-cycle write strobe
ins_read_enable  output  1  held 0 while busy, 1 otherwise (CPU fetch allowed)
cpu_hold  output  1  high while loading; drives pc_reset
load_busy  output  1  high in HDR0, HDR1, DATA and WRITE
load_done  output  1  high in DONE until the next load_start or reset
load_overflow  output  1  sticky; set if word count > DEPTH_WORDS; cleared on load_start
words_written  output  16  number of words actually written this load

Behaviour:
- Reset (reset_n=0 at a clk edge) puts the block in IDLE. All outputs are 0 except ins_read_enable=1. ins_address=BASE_ADDR and words_written=0.
- Reset mid-load aborts immediately. Memory contents already written are left as they are. cpu_hold drops the cycle after reset.
- States and transitions:
  - IDLE: on load_start go to HDR0.
  - HDR0: accept one byte as count[7:0], then go to HDR1.
  - HDR1: accept one byte as count[15:8], then go to DATA if count != 0, else DONE.
  - DATA: accept bytes into byte_idx 0..3, with byte k placed at word[8k+7:8k]. After byte 3 is accepted, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - If word_idx < DEPTH_WORDS: ins_write_enable=1, ins_address=BASE_ADDR+4*word_idx, ins_write_data=assembled word, words_written increments.
    - Otherwise: no strobe, and load_overflow is set.
    - word_idx increments. If word_idx+1 == count go to DONE, else go to DATA.
  - DONE: load_done=1. A load_start here re-enters HDR0 and clears load_done, load_overflow and words_written.
- in_ready = 1 in HDR0, HDR1 and DATA; 0 in IDLE, WRITE and DONE. Bytes are never dropped: data transfers only when in_valid && in_ready.
- in_valid low stalls the FSM in place indefinitely with no timeout. Partial words are retained across stalls.
- Throughput is one word per 5 cycles with in_valid held high: 4 accept cycles plus 1 WRITE.
- ins_address, ins_write_data and ins_write_enable are registered and valid in the WRITE cycle. ins_address holds its last value outside WRITE.
- cpu_hold = load_busy, registered. It asserts the cycle after load_start is sampled. It deasserts in the same cycle load_done rises.
- ins_read_enable = ~load_busy.
- load_start while busy is ignored and does not restart the load.
- word_idx is 16 bits. The address computation is done at ADDR_W and wraps modulo 2^ADDR_W. A count of 65535 is legal.
- An overflowing load still consumes all count*4 bytes so the stream stays aligned. words_written saturates at DEPTH_WORDS.

Test Plan:
- Reset then load_start; stream 02 00 13 05 10 00 93 05 20 00 (count=2) -> two WRITE strobes at addr 0x0 data 0x00100513 and addr 0x4 data 0x00200593. Then load_done=1, words_written=2, cpu_hold falls.
- Same image with in_valid toggling every other cycle -> identical writes. in_ready=0 exactly on WRITE cycles. No extra strobes.
- Header 00 00 (count=0) -> DONE right after the second header byte, no ins_write_enable, words_written=0.
- DEPTH_WORDS=4, count=6, 24 data bytes -> 4 writes at 0x0..0xC, load_overflow=1, words_written=4. All 26 bytes are accepted and the FSM reaches DONE.
- reset_n=0 after the 2nd data byte of word 1 -> next cycle state IDLE, cpu_hold=0, ins_read_enable=1. A new load then writes from BASE_ADDR again.
- load_start pulsed during DATA -> ignored and the load completes normally. load_start in DONE -> load_done clears, load_overflow clears, next header accepted.
